// File: rtl/tap_classifier.sv
// Tap classifier: groups debounced tap pulses into single/double(/triple) events held for a ready/valid consumer.
// Build option: define TAP_TRIPLE_EN to report a third tap as a triple event instead of double + new sequence.
module tap_classifier #(
  parameter int WINDOW = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       busy,
  output logic       overflow
);

  // state | meaning
  // IDLE  | no sequence open
  // ONE   | one tap seen, waiting for another or timeout
  // TWO   | two taps seen, waiting for another or timeout
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_t;

  localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  state_t        state;
  logic [CW-1:0] count;
  logic          timeout;
  logic          emit;
  logic [1:0]    emit_code;

  assign timeout = (count == CW'(WINDOW - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    emit      = 1'b0;
    emit_code = 2'b00;
    case (state)
      ONE: begin
        if (!pulse_in && timeout) begin
          emit      = 1'b1;
          emit_code = 2'b01;
        end
      end
      TWO: begin
        if (pulse_in) begin
          emit = 1'b1;
`ifdef TAP_TRIPLE_EN
          emit_code = 2'b11;
`else
          emit_code = 2'b10;
`endif
        end else if (timeout) begin
          emit      = 1'b1;
          emit_code = 2'b10;
        end
      end
      default: begin
        emit      = 1'b0;
        emit_code = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_code  <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (pulse_in) state <= ONE;
        end
        ONE: begin
          if (pulse_in) begin
            state <= TWO;
            count <= '0;
          end else if (timeout) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        TWO: begin
          if (pulse_in) begin
`ifdef TAP_TRIPLE_EN
            state <= IDLE;
`else
            state <= ONE;
`endif
            count <= '0;
          end else if (timeout) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase

      // Holding register: a stalled consumer keeps its event; newer events are dropped.
      if (!evt_valid || evt_ready) begin
        if (emit) begin
          evt_valid <= 1'b1;
          evt_code  <= emit_code;
        end else begin
          evt_valid <= 1'b0;
        end
      end else if (emit) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tap_classifier.md
TAP_CLASSIFIER -- requirements
Module: tap_classifier

Interface
REQ-001 Parameter WINDOW, default 25000000, SHALL set the inter-tap window in clk cycles; legal range 2 to 2^26-1.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 pulse_in  input  1  SHALL carry one-cycle tap pulses from the debounce stage.
REQ-005 evt_valid  output  1  SHALL indicate that a classified event is held for the consumer.
REQ-006 evt_code  output  2  SHALL encode the held event: 01 single, 10 double, 11 triple; 00 is never presented with evt_valid=1.
REQ-007 evt_ready  input  1  SHALL indicate the consumer accepts the held event this cycle.
REQ-008 busy  output  1  SHALL be high while a tap sequence is open (FSM not IDLE).
REQ-009 overflow  output  1  SHALL be a sticky flag set when an event is dropped.

Function
REQ-010 FSM states SHALL be IDLE, ONE (one tap seen), TWO (two taps seen).
REQ-011 A window counter, width ceil(log2(WINDOW)), SHALL clear on every entry to ONE or TWO and increment by 1 each cycle spent in ONE or TWO.
REQ-012 In IDLE, pulse_in=1 SHALL move to ONE; otherwise remain in IDLE.
REQ-013 In ONE, pulse_in=1 SHALL move to TWO; else if counter==WINDOW-1 SHALL emit single (01) and move to IDLE.
REQ-014 In TWO, counter==WINDOW-1 with pulse_in=0 SHALL emit double (10) and move to IDLE.
REQ-015 A pulse arriving in the same cycle as timeout SHALL count as a tap; the tap takes priority over timeout.
REQ-016 Emitted event SHALL appear on evt_valid/evt_code on the cycle after the emitting edge, i.e. a lone tap yields evt_valid WINDOW+1 cycles after pulse_in.
REQ-017 Output holding register SHALL load a new event when evt_valid=0, or when evt_valid=1 and evt_ready=1 in the same cycle.
REQ-018 Transfer completes on a cycle with evt_valid=1 and evt_ready=1; with no new event, evt_valid SHALL drop on the next cycle.
REQ-019 evt_valid and evt_code SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-020 An event emitted while evt_valid=1 and evt_ready=0 SHALL be discarded, the held event SHALL be kept, and overflow SHALL be set.
REQ-021 overflow SHALL clear only on rst.
REQ-022 busy SHALL be combinational from the FSM state; evt_valid, evt_code and overflow SHALL be registered.

Reset
REQ-023 rst=1 SHALL force: state IDLE, counter 0, evt_valid 0, evt_code 00, overflow 0, busy 0.
REQ-024 rst asserted mid-sequence SHALL abandon the open sequence without emitting an event.
REQ-025 rst SHALL override any pulse_in or evt_ready in the same cycle.

Configuration
REQ-026 Macro TAP_TRIPLE_EN SHALL gate triple-tap detection.
REQ-027 With TAP_TRIPLE_EN defined, pulse_in=1 in TWO SHALL emit triple (11) and move to IDLE.
REQ-028 Without TAP_TRIPLE_EN, pulse_in=1 in TWO SHALL emit double (10) and move to ONE with the counter cleared, starting a new sequence; code 11 SHALL never be produced.

Verification (WINDOW=8)
REQ-029 Single pulse at cycle 0, evt_ready=1 -> busy high cycles 1-8; evt_valid=1 with code 01 only at cycle 9.
REQ-030 Pulses at cycles 0 and 5, ready=1 -> code 10 presented for one cycle, 8 cycles after the second pulse's state entry (cycle 14).
REQ-031 Pulses at 0, 3 and 6 -> with TAP_TRIPLE_EN: code 11 at cycle 7. Without it: code 10 at cycle 7, then code 01 at cycle 15.
REQ-032 Second pulse exactly on the timeout cycle (cycle 8 after first) -> no single emitted; sequence continues in TWO.
REQ-033 evt_ready=0 held; two separate single taps 20 cycles apart -> first 01 held stable, second dropped, overflow=1. Raising ready -> one transfer, then evt_valid=0 and overflow stays 1.
REQ-034 rst pulse at cycle 4 after a tap -> no event ever emitted; busy=0 and all outputs at reset values from cycle 5.
